// File: rtl/riscv_pkg.sv
// Shared fetch-path types and constants for the riscv_pipeline front end.
// No logic, no latency.
// No flow control; consumers own their handshakes.
package riscv_pkg;

   localparam int XLEN    = 32;
   localparam int ILEN    = 32;
   localparam int PC_STEP = 4;

   // One fetched instruction together with the address it came from.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;

   // Sequential successor of a PC; wraps modulo 2^32 by construction.
   function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
      return pc + XLEN'(PC_STEP);
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch_entry_t between imem response and decode.
// Latency: an entry pushed on an edge is visible at the head right after that edge.
// Backpressure: none internally; the caller never pushes when full. Flush beats push/pop.
module fetch_queue
   import riscv_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  fetch_entry_t                 push_dat,
   input  logic                         pop,
   input  logic                         flush,
   output fetch_entry_t                 head_dat,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   fetch_entry_t   slots [DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;

   // Ring-buffer pointer advance that also works for non-power-of-two depths.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Pointer and occupancy bookkeeping; a flush empties the queue in one edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Entry storage carries no reset; stale slots are never exposed while empty.
   always_ff @(posedge clk) begin
      if (push && !flush) slots[wr_ptr] <= push_dat;
   end

   assign head_dat = slots[rd_ptr];
   assign empty    = (count == '0);

endmodule

// File: rtl/riscv_fetch_stage.sv
// IF stage: owns the PC, reads a 1-cycle synchronous imem, queues {pc,instr} for decode.
// Latency: first instruction valid after the 2nd edge past reset or redirect; 1 instr/cycle sustained.
// Backpressure: if_ready low stalls the head; requests stop once queue plus in-flight fill FQ_DEPTH.
// Optional feature: FETCH_MISALIGN_TRAP_EN adds if_misalign and halts fetch on a misaligned redirect.
module riscv_fetch_stage
   import riscv_pkg::*;
#(
   parameter int FQ_DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [XLEN-1:0]  pc_init,
   output logic             imem_req,
   output logic [XLEN-1:0]  imem_addr,
   input  logic [ILEN-1:0]  imem_rdata,
   input  logic             redirect_e,
   input  logic [XLEN-1:0]  redirect_pc,
   output logic             if_valid,
   input  logic             if_ready,
   output logic [XLEN-1:0]  if_pc,
   output logic [ILEN-1:0]  if_instr
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   output logic             if_misalign
`endif
);

   localparam int CW = $clog2(FQ_DEPTH + 1);

   logic [XLEN-1:0]  pc;
   logic [XLEN-1:0]  req_pc;
   logic [XLEN-1:0]  redirect_tgt;
   logic             inflight;
   logic             issue;
   logic             push;
   logic             pop;
   logic             flush;
   logic             fetch_hold;
   logic             empty;
   logic [CW-1:0]    count;
   logic [CW:0]      occupancy;
   fetch_entry_t     push_dat;
   fetch_entry_t     head;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic halted;
   logic trap_hit;

   assign trap_hit     = |redirect_pc[1:0];
   assign redirect_tgt = redirect_pc;
   assign fetch_hold   = halted;
   assign if_misalign  = halted;

   // Trap state follows the alignment of the most recent redirect target.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)           halted <= 1'b0;
      else if (redirect_e) halted <= trap_hit;
   end
`else
   // Low address bits of a redirect are simply dropped.
   assign redirect_tgt = redirect_pc & ~XLEN'(3);
   assign fetch_hold   = 1'b0;
`endif

   // Entries that will occupy the queue after this edge. The head leaving this
   // cycle frees its slot in time for a request issued now, which is what lets
   // two entries sustain one instruction per cycle without ever overflowing.
   assign pop       = if_valid && if_ready;
   assign occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);

   assign issue     = !reset && !redirect_e && !fetch_hold &&
                      (occupancy < (CW+1)'(FQ_DEPTH));
   assign imem_req  = issue;
   assign imem_addr = pc;

   // A response arriving on a redirect edge belongs to the old path and is dropped.
   assign push      = inflight && !redirect_e;
   assign flush     = redirect_e || fetch_hold;
   assign push_dat  = '{pc: req_pc, instr: imem_rdata};

   // PC, in-flight flag and request address; redirect overrides normal sequencing.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc       <= pc_init;
         req_pc   <= '0;
         inflight <= 1'b0;
      end else if (redirect_e) begin
         pc       <= redirect_tgt;
         inflight <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) begin
            pc     <= pc_next(pc);
            req_pc <= pc;
         end
      end
   end

   fetch_queue #(
      .DEPTH    (FQ_DEPTH)
   ) u_fetch_queue (
      .clk      (clk),
      .rst      (reset),
      .push     (push),
      .push_dat (push_dat),
      .pop      (pop),
      .flush    (flush),
      .head_dat (head),
      .count    (count),
      .empty    (empty)
   );

   assign if_valid = !empty;
   assign if_pc    = head.pc;
   assign if_instr = head.instr;

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// Self-checking bench for riscv_fetch_stage: directed scenarios plus a random phase.
// Reference model: program-order PC stream restarted on each redirect, checked at every handshake.
// Works with and without FETCH_MISALIGN_TRAP_EN.
module tb_riscv_fetch_stage;

   localparam int FQ_DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] pc_init = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'h0;
   logic        redirect_e = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        if_valid;
   logic        if_ready = 1'b0;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        if_misalign;
`endif

   riscv_fetch_stage #(.FQ_DEPTH(FQ_DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .pc_init     (pc_init),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .redirect_e  (redirect_e),
      .redirect_pc (redirect_pc),
      .if_valid    (if_valid),
      .if_ready    (if_ready),
      .if_pc       (if_pc),
      .if_instr    (if_instr)
`ifdef FETCH_MISALIGN_TRAP_EN
      ,
      .if_misalign (if_misalign)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Instruction memory contents: two fixed words, everything else address-derived.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h0000_2083;
         32'h0000_0004: return 32'h0040_2103;
         default:       return a ^ 32'hC3A5_5A3C;
      endcase
   endfunction

   // Synchronous memory: the address seen at an edge is answered during the next cycle.
   logic [31:0] mem_a;
   always @(posedge clk) begin
      mem_a = imem_addr;
      #1 imem_rdata = mem_word(mem_a);
   end

   // Reference model state.
   logic [31:0] exp_pc = 32'h0;
   bit          halted_m = 1'b0;
   bit          post_redir = 1'b0;
   bit          hold_pending = 1'b0;
   logic [31:0] held_pc, held_instr;
   int          delivered = 0;
   int          d0;

   // Samples taken at the falling edge of the most recent cycle.
   logic [31:0] s_valid, s_pc, s_instr, s_req, s_addr, s_mis;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One clock cycle: apply inputs, sample and check mid-cycle, then advance the model.
   task automatic cyc(input bit rdy, input bit redir, input logic [31:0] rpc);
      if_ready    = rdy;
      redirect_e  = redir;
      redirect_pc = rpc;
      @(negedge clk);
      s_valid = 32'(if_valid);
      s_pc    = if_pc;
      s_instr = if_instr;
      s_req   = 32'(imem_req);
      s_addr  = imem_addr;
`ifdef FETCH_MISALIGN_TRAP_EN
      s_mis   = 32'(if_misalign);
`else
      s_mis   = 32'h0;
`endif
      if (post_redir) chk("redir_bubble", s_valid, 0);
      if (hold_pending) begin
         chk("hold_valid", s_valid, 1);
         chk("hold_pc", s_pc, held_pc);
         chk("hold_instr", s_instr, held_instr);
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      if (halted_m) begin
         chk("halt_noreq", s_req, 0);
         chk("halt_novalid", s_valid, 0);
         chk("halt_flag", s_mis, 1);
      end else begin
         chk("misalign_clear", s_mis, 0);
      end
`endif
      if (redir) chk("redir_noreq", s_req, 0);
      if (s_req == 32'h1) chk("req_align", {30'b0, s_addr[1:0]}, 0);
      if (s_valid == 32'h1 && rdy) begin
         chk("deliver_pc", s_pc, exp_pc);
         chk("deliver_instr", s_instr, mem_word(exp_pc));
         exp_pc = exp_pc + 32'd4;
         delivered++;
      end
      hold_pending = (s_valid == 32'h1) && !rdy && !redir;
      held_pc      = s_pc;
      held_instr   = s_instr;
      post_redir   = redir;
      if (redir) begin
`ifdef FETCH_MISALIGN_TRAP_EN
         if (rpc[1:0] != 2'b00) begin
            halted_m = 1'b1;
         end else begin
            halted_m = 1'b0;
            exp_pc   = rpc;
         end
`else
         exp_pc = rpc & ~32'd3;
`endif
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [31:0] p0);
      pc_init    = p0;
      if_ready   = 1'b0;
      redirect_e = 1'b0;
      reset      = 1'b1;
      #2;
      chk("rst_valid", 32'(if_valid), 0);
      chk("rst_req", 32'(imem_req), 0);
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("rst_misalign", 32'(if_misalign), 0);
`endif
      repeat (2) @(posedge clk);
      #1;
      reset        = 1'b0;
      exp_pc       = p0;
      halted_m     = 1'b0;
      post_redir   = 1'b0;
      hold_pending = 1'b0;
   endtask

   initial begin
      bit          rdy, redir;
      logic [31:0] rpc;

      // Scenario 1: latency and back-to-back delivery from pc_init=0.
      do_reset(32'h0);
      cyc(1, 0, 0);
      chk("t1_req0", s_req, 1);
      chk("t1_addr0", s_addr, 32'h0);
      chk("t1_lat0", s_valid, 0);
      cyc(1, 0, 0);
      chk("t1_lat1", s_valid, 0);
      cyc(1, 0, 0);
      chk("t1_valid0", s_valid, 1);
      chk("t1_pc0", s_pc, 32'h0);
      chk("t1_instr0", s_instr, 32'h0000_2083);
      cyc(1, 0, 0);
      chk("t1_pc4", s_pc, 32'h4);
      chk("t1_instr4", s_instr, 32'h0040_2103);
      for (int i = 0; i < 6; i++) begin
         cyc(1, 0, 0);
         chk("t1_stream", s_valid, 1);
      end

      // Scenario 2: decode stalls, queue fills, requests stop, nothing lost on release.
      do_reset(32'h0);
      for (int i = 0; i < 7; i++) cyc(0, 0, 0);
      chk("t2_stall_valid", s_valid, 1);
      chk("t2_stall_noreq", s_req, 0);
      chk("t2_stall_head", s_pc, 32'h0);
      d0 = delivered;
      for (int i = 0; i < 3; i++) cyc(1, 0, 0);
      chk("t2_release_count", 32'(delivered - d0), 3);

      // Scenario 3: redirect while the queue holds stale entries.
      for (int i = 0; i < 3; i++) cyc(0, 0, 0);
      chk("t3_full", s_valid, 1);
      cyc(0, 1, 32'h40);
      cyc(1, 0, 0);
      chk("t3_req", s_req, 1);
      chk("t3_addr", s_addr, 32'h40);
      cyc(1, 0, 0);
      chk("t3_bubble2", s_valid, 0);
      cyc(1, 0, 0);
      chk("t3_valid", s_valid, 1);
      chk("t3_pc", s_pc, 32'h40);
      chk("t3_instr", s_instr, mem_word(32'h40));

      // Scenario 4: PC wraps from the top of the address space.
      do_reset(32'hFFFF_FFF8);
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      chk("t4_pc_f8", s_pc, 32'hFFFF_FFF8);
      cyc(1, 0, 0);
      chk("t4_pc_fc", s_pc, 32'hFFFF_FFFC);
      cyc(1, 0, 0);
      chk("t4_pc_wrap", s_pc, 32'h0);
      chk("t4_valid_wrap", s_valid, 1);

      // Scenario 5: asynchronous reset mid-stream, restart at a new pc_init.
      cyc(1, 0, 0);
      chk("t5_pre_valid", s_valid, 1);
      pc_init = 32'h100;
      #2 reset = 1'b1;
      #1;
      chk("t5_async_valid", 32'(if_valid), 0);
      chk("t5_async_req", 32'(imem_req), 0);
      repeat (2) @(posedge clk);
      #1;
      reset        = 1'b0;
      exp_pc       = 32'h100;
      post_redir   = 1'b0;
      hold_pending = 1'b0;
      halted_m     = 1'b0;
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      chk("t5_restart_pc", s_pc, 32'h100);

      // Scenario 6: misaligned redirect.
`ifdef FETCH_MISALIGN_TRAP_EN
      cyc(1, 1, 32'h42);
      for (int i = 0; i < 3; i++) cyc(1, 0, 0);
      chk("t6_trap_flag", s_mis, 1);
      chk("t6_trap_noreq", s_req, 0);
      cyc(1, 1, 32'h80);
      cyc(1, 0, 0);
      chk("t6_trap_cleared", s_mis, 0);
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      chk("t6_resume_pc", s_pc, 32'h80);
`else
      cyc(1, 1, 32'h42);
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      chk("t6_align_pc", s_pc, 32'h40);
      chk("t6_align_instr", s_instr, mem_word(32'h40));
`endif

      // Random phase: random stalls and redirects against the program-order model.
      for (int i = 0; i < 400; i++) begin
         rdy   = ($urandom_range(0, 9) < 7);
         redir = ($urandom_range(0, 19) == 0);
         rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1C))
                                              : ($urandom & 32'h0000_0FFC);
         if ($urandom_range(0, 3) == 0) rpc = rpc | 32'($urandom_range(1, 3));
         cyc(rdy, redir, rpc);
      end

      // Final redirect then full-rate drain: two bubbles, then one instruction per cycle.
      cyc(1, 1, 32'h200);
      d0 = delivered;
      for (int i = 0; i < 10; i++) cyc(1, 0, 0);
      chk("throughput", 32'(delivered - d0), 8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
